// File: rtl/uart_tx_arbiter.sv
// Three-requester byte arbiter in front of one UART transmitter, with per-owner message locking.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module uart_tx_arbiter #(
   parameter logic [7:0] HOLD_MAX = 8'd64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [2:0] last,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   output logic [2:0] ack,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [1:0] owner,
   output logic       locked
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] burst;
   logic [7:0] burst_inc;
   logic [1:0] wait_cnt;
   logic [1:0] pick;
   logic [1:0] winner;
   logic [7:0] winner_data;
   logic       grant;
   logic       release_lock;
   logic       owner_req;
   logic       owner_last;
   logic       hold_hit;
   logic [3:0] req_ext;
   logic [3:0] last_ext;

   // owner may be 3 (nobody), so index through a zero-padded copy
   assign req_ext    = {1'b0, req};
   assign last_ext   = {1'b0, last};
   assign owner_req  = req_ext[owner];
   assign owner_last = last_ext[owner];
   assign burst_inc  = (burst == 8'hFF) ? burst : burst + 8'd1;
   assign hold_hit   = (HOLD_MAX != 8'd0) && (burst_inc >= HOLD_MAX);

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] rr_ptr;
   logic [1:0] cand1;
   logic [1:0] cand2;

   assign cand1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
   assign cand2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;

   always_comb begin
      pick = 2'd3;
      if (req_ext[rr_ptr])
         pick = rr_ptr;
      else if (req_ext[cand1])
         pick = cand1;
      else if (req_ext[cand2])
         pick = cand2;
   end

   // rr_ptr is the first index searched, i.e. one past the latest launch
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= 2'd0;
      else if (state == LAUNCH)
         rr_ptr <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
   end
`else
   always_comb begin
      pick = 2'd3;
      if (req[0])
         pick = 2'd0;
      else if (req[1])
         pick = 2'd1;
      else if (req[2])
         pick = 2'd2;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Launch is held off in IDLE while the transmitter is busy, which also covers frames left over from a reset
   always_comb begin
      state_next   = state;
      grant        = 1'b0;
      winner       = pick;
      release_lock = 1'b0;
      tx_start     = 1'b0;
      ack          = 3'b000;
      case (state)
         IDLE: begin
            if (!tx_busy) begin
               if (locked && owner_req) begin
                  grant  = 1'b1;
                  winner = owner;
               end else begin
                  release_lock = locked;
                  grant        = (pick != 2'd3);
               end
            end
            if (grant)
               state_next = LAUNCH;
         end
         LAUNCH: begin
            tx_start   = !rst;
            ack        = rst ? 3'b000 : (3'b001 << owner);
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy || (wait_cnt == 2'd3))
               state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      case (winner)
         2'd0:    winner_data = data0;
         2'd1:    winner_data = data1;
         default: winner_data = data2;
      endcase
   end

   // burst counts bytes sent in the current lock, including the one that opened it
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data  <= 8'h00;
         owner    <= 2'd3;
         locked   <= 1'b0;
         burst    <= 8'd0;
         wait_cnt <= 2'd0;
      end else begin
         if (release_lock) begin
            locked <= 1'b0;
            burst  <= 8'd0;
         end
         if (grant) begin
            owner   <= winner;
            tx_data <= winner_data;
         end
         if (state == LAUNCH) begin
            if (owner_last || hold_hit) begin
               locked <= 1'b0;
               burst  <= 8'd0;
            end else begin
               locked <= 1'b1;
               burst  <= burst_inc;
            end
         end
         if (state == WAIT_BUSY)
            wait_cnt <= wait_cnt + 2'd1;
         else
            wait_cnt <= 2'd0;
      end
   end

endmodule
